// File: rtl/gesture_pkg.sv
// Shared definitions for the gesture pipeline: centroid FSM states and the
// default active-area size that the gesture FSMs also use for region lines.
package gesture_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        DIVIDE  = 2'd1,
        PUBLISH = 2'd2
    } centroid_state_t;

    localparam int DEFAULT_MAX_X = 1024;
    localparam int DEFAULT_MAX_Y = 768;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock. The first bit is
// produced on the start edge itself, so a WIDTH-bit quotient takes WIDTH
// edges including the start edge; done pulses on the cycle after the last one.
module seq_divider #(
    parameter int WIDTH = 31
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int CW = $clog2(WIDTH + 1);

    // dq_reg: remaining dividend bits leave at the top, quotient bits enter at the bottom
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [WIDTH-1:0] dq_reg, dq_next;
    logic [WIDTH-1:0] dvs_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg, done_reg;
    logic             load;
    logic [WIDTH-1:0] rem_in, dq_in, dvs_in;
    logic [WIDTH:0]   trial, diff;

    assign load = start & ~busy_reg;

    // One restoring step, fed either by fresh operands (start) or by the running state
    always_comb begin
        rem_in = load ? '0       : rem_reg;
        dq_in  = load ? dividend : dq_reg;
        dvs_in = load ? divisor  : dvs_reg;
        trial  = {rem_in, dq_in[WIDTH-1]};
        diff   = trial - {1'b0, dvs_in};
        if (trial >= {1'b0, dvs_in}) begin
            rem_next = diff[WIDTH-1:0];
            dq_next  = {dq_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = trial[WIDTH-1:0];
            dq_next  = {dq_in[WIDTH-2:0], 1'b0};
        end
    end

    // Iteration state; reset aborts any division in flight
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rem_reg  <= '0;
            dq_reg   <= '0;
            dvs_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                rem_reg  <= rem_next;
                dq_reg   <= dq_next;
                dvs_reg  <= divisor;
                cnt_reg  <= CW'(WIDTH - 1);
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                rem_reg <= rem_next;
                dq_reg  <= dq_next;
                cnt_reg <= cnt_reg - 1'b1;
                if (cnt_reg == CW'(1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign quotient = dq_reg;

endmodule

// File: rtl/centroid_tracker.sv
// Per-frame centroid of thresholded pixels. Sums and a match count run
// continuously; each frame_end snapshots them, and the FSM either divides
// (enough matches) or publishes a zero "not found" result. Outputs hold
// between frames.
module centroid_tracker
    import gesture_pkg::*;
#(
    parameter int H_WIDTH    = 11,
    parameter int V_WIDTH    = 10,
    parameter int MAX_X      = DEFAULT_MAX_X,
    parameter int MAX_Y      = DEFAULT_MAX_Y,
    parameter int CNT_WIDTH  = 20,
    parameter int SUM_WIDTH  = 31,
    parameter int MIN_PIXELS = 64
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               pixel_valid,
    input  logic [H_WIDTH-1:0] hcount,
    input  logic [V_WIDTH-1:0] vcount,
    input  logic               pixel_match,
    input  logic               frame_end,
    output logic [15:0]        x,
    output logic [15:0]        y,
    output logic               found,
    output logic               centroid_valid,
    output logic               overrun
);

    if (MIN_PIXELS < 1) begin : g_min_pixels_check
        $error("centroid_tracker: MIN_PIXELS must be at least 1");
    end

    localparam logic [H_WIDTH:0]     X_LIMIT   = (H_WIDTH + 1)'(MAX_X);
    localparam logic [V_WIDTH:0]     Y_LIMIT   = (V_WIDTH + 1)'(MAX_Y);
    localparam logic [CNT_WIDTH-1:0] MIN_COUNT = CNT_WIDTH'(MIN_PIXELS);

    centroid_state_t state_reg, state_next;

    logic                           pix_hit;
    logic                           fe_accept, fe_collide, fe_pending_reg;
    logic                           count_ok;
    logic [CNT_WIDTH-1:0]           count_reg, count_acc, snap_cnt_reg;
    logic [1:0][SUM_WIDTH-1:0]      coord_ext, div_quot;
    logic [1:0]                     div_busy, div_done;
    logic                           div_start, pub_load, pub_found;
    logic [15:0]                    x_reg, y_reg;
    logic                           found_reg, overrun_reg;

    assign pix_hit = pixel_valid & pixel_match &
                     ({1'b0, hcount} < X_LIMIT) & ({1'b0, vcount} < Y_LIMIT);

    // A frame_end is only taken while idle with nothing queued; otherwise its frame is dropped
    assign fe_accept  = frame_end & (state_reg == ACCUM) & ~fe_pending_reg;
    assign fe_collide = frame_end & ~fe_accept;

    assign coord_ext[0] = SUM_WIDTH'(hcount);
    assign coord_ext[1] = SUM_WIDTH'(vcount);
    assign count_acc    = count_reg + CNT_WIDTH'(pix_hit);
    assign count_ok     = snap_cnt_reg >= MIN_COUNT;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            logic [SUM_WIDTH-1:0] sum_reg, sum_acc, snap_reg;

            // The pixel on the frame_end cycle still belongs to the closing frame
            assign sum_acc = sum_reg + (pix_hit ? coord_ext[gi] : '0);

            // Per-axis running sum, cleared at every frame boundary
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    sum_reg  <= '0;
                    snap_reg <= '0;
                end else begin
                    sum_reg <= frame_end ? '0 : sum_acc;
                    if (fe_accept) begin
                        snap_reg <= sum_acc;
                    end
                end
            end

            seq_divider #(
                .WIDTH(SUM_WIDTH)
            ) u_div (
                .clock   (clock),
                .reset_n (reset_n),
                .start   (div_start),
                .dividend(snap_reg),
                .divisor (SUM_WIDTH'(snap_cnt_reg)),
                .busy    (div_busy[gi]),
                .done    (div_done[gi]),
                .quotient(div_quot[gi])
            );
        end
    endgenerate

    // Match counter, frame snapshot and the accepted-frame handoff flag
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_reg      <= '0;
            snap_cnt_reg   <= '0;
            fe_pending_reg <= 1'b0;
        end else begin
            count_reg      <= frame_end ? '0 : count_acc;
            fe_pending_reg <= fe_accept;
            if (fe_accept) begin
                snap_cnt_reg <= count_acc;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg <= ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state, divider start and result-load strobes
    always_comb begin
        state_next = state_reg;
        div_start  = 1'b0;
        pub_load   = 1'b0;
        pub_found  = 1'b0;
        case (state_reg)
            ACCUM: begin
                if (fe_pending_reg) begin
                    if (count_ok) begin
                        state_next = DIVIDE;
                        div_start  = 1'b1;
                    end else begin
                        state_next = PUBLISH;
                        pub_load   = 1'b1;
                    end
                end
            end
            DIVIDE: begin
                if ((&div_done) && !(|div_busy)) begin
                    state_next = PUBLISH;
                    pub_load   = 1'b1;
                    pub_found  = 1'b1;
                end
            end
            PUBLISH: state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Result registers load on entry to PUBLISH so they change together with centroid_valid
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            x_reg       <= '0;
            y_reg       <= '0;
            found_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (pub_load) begin
                x_reg     <= pub_found ? 16'(div_quot[0]) : 16'd0;
                y_reg     <= pub_found ? 16'(div_quot[1]) : 16'd0;
                found_reg <= pub_found;
            end
            if (fe_collide) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign x              = x_reg;
    assign y              = y_reg;
    assign found          = found_reg;
    assign centroid_valid = (state_reg == PUBLISH);
    assign overrun        = overrun_reg;

endmodule

// File: tb/tb_centroid_tracker.sv
// Directed bench for centroid_tracker: a frame-level reference model predicts
// published results and their timing; a compare process checks the outputs
// every cycle, and each test also checks hand-computed literals.
module tb_centroid_tracker;

    localparam int H_WIDTH    = 11;
    localparam int V_WIDTH    = 10;
    localparam int MAX_X      = 1024;
    localparam int MAX_Y      = 768;
    localparam int SUM_WIDTH  = 31;
    localparam int MIN_PIXELS = 64;

    logic               clock;
    logic               reset_n;
    logic               pixel_valid;
    logic [H_WIDTH-1:0] hcount;
    logic [V_WIDTH-1:0] vcount;
    logic               pixel_match;
    logic               frame_end;
    logic [15:0]        x, y;
    logic               found, centroid_valid, overrun;

    int n_cmp  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    centroid_tracker #(
        .H_WIDTH   (H_WIDTH),
        .V_WIDTH   (V_WIDTH),
        .MAX_X     (MAX_X),
        .MAX_Y     (MAX_Y),
        .CNT_WIDTH (20),
        .SUM_WIDTH (SUM_WIDTH),
        .MIN_PIXELS(MIN_PIXELS)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pixel_valid   (pixel_valid),
        .hcount        (hcount),
        .vcount        (vcount),
        .pixel_match   (pixel_match),
        .frame_end     (frame_end),
        .x             (x),
        .y             (y),
        .found         (found),
        .centroid_valid(centroid_valid),
        .overrun       (overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic cmp(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    int          cyc      = 0;
    longint      m_sx     = 0, m_sy = 0, m_n = 0;
    logic [15:0] m_x      = 0, m_y = 0;
    logic        m_found  = 0, m_valid = 0, m_overrun = 0;
    logic        pend     = 0;
    int          pend_cyc = 0;
    int          last_pub = -100;
    logic [15:0] pend_x   = 0, pend_y = 0;
    logic        pend_found = 0;

    always @(posedge clock) begin
        cyc++;
        m_valid = 1'b0;
        if (!reset_n) begin
            m_sx = 0; m_sy = 0; m_n = 0;
            m_x = 0; m_y = 0; m_found = 0; m_overrun = 0;
            pend = 0; last_pub = -100;
        end else begin
            if (pend && cyc == pend_cyc) begin
                m_x = pend_x; m_y = pend_y; m_found = pend_found;
                m_valid = 1'b1;
                pend = 0;
            end
            if (pixel_valid && pixel_match && int'(hcount) < MAX_X && int'(vcount) < MAX_Y) begin
                m_sx += longint'(hcount);
                m_sy += longint'(vcount);
                m_n  += 1;
            end
            if (frame_end) begin
                if (cyc <= last_pub + 1) begin
                    m_overrun = 1'b1;
                end else begin
                    if (m_n >= MIN_PIXELS) begin
                        pend_x = 16'(m_sx / m_n);
                        pend_y = 16'(m_sy / m_n);
                        pend_found = 1'b1;
                        pend_cyc = cyc + SUM_WIDTH + 1;
                    end else begin
                        pend_x = 0; pend_y = 0; pend_found = 1'b0;
                        pend_cyc = cyc + 1;
                    end
                    pend = 1;
                    last_pub = pend_cyc;
                end
                m_sx = 0; m_sy = 0; m_n = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clock) begin
        if (chk_en) begin
            cmp("cyc_valid",   centroid_valid, m_valid);
            cmp("cyc_x",       x,              m_x);
            cmp("cyc_y",       y,              m_y);
            cmp("cyc_found",   found,          m_found);
            cmp("cyc_overrun", overrun,        m_overrun);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input int h, input int vv, input logic m, input logic fe);
        @(posedge clock); #1;
        pixel_valid = v;
        hcount      = h[H_WIDTH-1:0];
        vcount      = vv[V_WIDTH-1:0];
        pixel_match = m;
        frame_end   = fe;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // w x h block of matching pixels, omitting the last 'skip' of them
    task automatic send_block(input int x0, input int y0, input int w, input int h, input int skip);
        int left;
        left = w * h - skip;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                if (left > 0) begin
                    drive(1'b1, x0 + c, y0 + r, 1'b1, 1'b0);
                    left--;
                end
    endtask

    // Idles the inputs after the cycle in flight and watches n cycles for result pulses
    task automatic watch(input int n, output int pulses, output int lat,
                         output logic [15:0] wx, output logic [15:0] wy, output logic wf);
        pulses = 0; lat = -1; wx = 0; wy = 0; wf = 0;
        @(posedge clock); #1;
        pixel_valid = 0; pixel_match = 0; frame_end = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            if (centroid_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = i; wx = x; wy = y; wf = found;
                end
            end
        end
    endtask

    task automatic check_result(input string tag, input int pulses, input int lat,
                                input logic [15:0] wx, input logic [15:0] wy, input logic wf,
                                input int e_lat, input int e_x, input int e_y, input int e_f);
        $display("%s: pulses=%0d latency=%0d x=%0d y=%0d found=%0d", tag, pulses, lat, wx, wy, wf);
        cmp({tag, "_pulses"},  pulses, 1);
        cmp({tag, "_latency"}, lat,    e_lat);
        cmp({tag, "_x"},       wx,     e_x);
        cmp({tag, "_y"},       wy,     e_y);
        cmp({tag, "_found"},   wf,     e_f);
    endtask

    initial begin
        int p, l;
        logic [15:0] wx, wy;
        logic wf;

        reset_n = 0; pixel_valid = 0; hcount = 0; vcount = 0; pixel_match = 0; frame_end = 0;
        repeat (3) @(posedge clock);
        #1;
        chk_en  = 1'b1;
        reset_n = 1;
        @(negedge clock);
        $display("reset: x=%0d y=%0d found=%0d valid=%0d overrun=%0d", x, y, found, centroid_valid, overrun);
        cmp("reset_x", x, 0);
        cmp("reset_y", y, 0);
        cmp("reset_found", found, 0);
        cmp("reset_valid", centroid_valid, 0);
        cmp("reset_overrun", overrun, 0);

        // 8x8 block around (503.5, 303.5)
        send_block(500, 300, 8, 8, 0);
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        watch(45, p, l, wx, wy, wf);
        check_result("block64", p, l, wx, wy, wf, 33, 503, 303, 1);

        // one pixel short of the threshold
        send_block(500, 300, 8, 8, 1);
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        watch(45, p, l, wx, wy, wf);
        check_result("block63", p, l, wx, wy, wf, 2, 0, 0, 0);

        // far corner of the active area, with out-of-range and non-matching pixels mixed in
        for (int r = 760; r < 768; r++) begin
            for (int c = 960; c < 1024; c++) drive(1'b1, c, r, 1'b1, 1'b0);
            drive(1'b1, 1024, r, 1'b1, 1'b0);
            drive(1'b1, 1000, 768, 1'b1, 1'b0);
            drive(1'b1, 10, 10, 1'b0, 1'b0);
            drive(1'b0, 10, 10, 1'b1, 1'b0);
        end
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        watch(45, p, l, wx, wy, wf);
        check_result("corner512", p, l, wx, wy, wf, 33, 991, 763, 1);

        // qualifying pixel on the frame_end cycle closes the frame
        for (int i = 0; i < 63; i++) drive(1'b1, 0, 0, 1'b1, 1'b0);
        drive(1'b1, 1023, 767, 1'b1, 1'b1);
        watch(45, p, l, wx, wy, wf);
        check_result("same_cycle", p, l, wx, wy, wf, 33, 15, 11, 1);

        // next frame must start from zero: 63 pixels is not enough
        send_block(5, 5, 8, 8, 1);
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        watch(45, p, l, wx, wy, wf);
        check_result("fresh63", p, l, wx, wy, wf, 2, 0, 0, 0);

        // second frame_end 10 cycles into the division
        send_block(500, 300, 8, 8, 0);
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) drive(1'b1, 1000, 700, 1'b1, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        watch(60, p, l, wx, wy, wf);
        check_result("collide", p, l, wx, wy, wf, 23, 503, 303, 1);
        cmp("collide_overrun", overrun, 1);

        // the dropped frame's pixels must not leak into the next frame
        send_block(10, 10, 8, 8, 1);
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        watch(45, p, l, wx, wy, wf);
        check_result("after_collide", p, l, wx, wy, wf, 2, 0, 0, 0);
        cmp("after_collide_overrun", overrun, 1);

        // reset pulse in the middle of a division
        send_block(200, 100, 8, 8, 0);
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        idle(9);
        @(posedge clock); #1;
        reset_n = 0; pixel_valid = 0; frame_end = 0;
        @(posedge clock); #1;
        reset_n = 1;
        @(negedge clock);
        $display("mid_reset: x=%0d y=%0d found=%0d overrun=%0d", x, y, found, overrun);
        cmp("midreset_x", x, 0);
        cmp("midreset_y", y, 0);
        cmp("midreset_found", found, 0);
        cmp("midreset_overrun", overrun, 0);
        watch(45, p, l, wx, wy, wf);
        $display("mid_reset watch: pulses=%0d", p);
        cmp("midreset_no_pulse", p, 0);

        send_block(100, 200, 8, 8, 0);
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        watch(45, p, l, wx, wy, wf);
        check_result("post_reset", p, l, wx, wy, wf, 33, 103, 203, 1);

        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
